// File: rtl/nbody_gravity_if.sv
// nbody_gravity_if: frame timing inputs and body position/status outputs of nbody_gravity
// Signals: frame_tick, blanking (into the engine); pos_x, pos_y, busy, done (out of the engine).
// Modports: master drives the timing inputs, slave is the gravity engine.
interface nbody_gravity_if #(
    parameter int NUM_BODIES = 3,
    parameter int INT_W = 11
);
    logic frame_tick;
    logic blanking;
    logic [NUM_BODIES*INT_W-1:0] pos_x;
    logic [NUM_BODIES*INT_W-1:0] pos_y;
    logic busy;
    logic done;
    modport master (output frame_tick, blanking, input pos_x, pos_y, busy, done);
    modport slave (input frame_tick, blanking, output pos_x, pos_y, busy, done);
endinterface

// File: rtl/nbody_gravity.sv
// nbody_gravity: fixed-point N-body gravity engine, one pairwise micro-step per blanking clock
// Ports: clk (pixel clock), reset (async, active-high), bus (nbody_gravity_if.slave):
//   frame_tick/blanking in; pos_x/pos_y (integer position per body, body 0 in LSBs), busy, done out.
// Optional GRAVITY_BOUNCE_EN: clamps positions to the screen on frame_tick and reflects velocity.
// INT_W must be at least 8 so the distance magnitude thresholds are representable.
module nbody_gravity #(
    parameter int NUM_BODIES = 3,
    parameter int INT_W = 11,
    parameter int FRAC_W = 3,
    parameter int VEL_W = 6,
    parameter logic [NUM_BODIES*INT_W-1:0] INIT_X = {11'sd320, 11'sd370, 11'sd270},
    parameter logic [NUM_BODIES*INT_W-1:0] INIT_Y = {11'sd160, 11'sd280, 11'sd200},
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input logic clk,
    input logic reset,
    nbody_gravity_if.slave bus
);
    localparam int PW = INT_W + FRAC_W;
    localparam int DW = INT_W + 1;
    localparam int AW = $clog2(NUM_BODIES);
    localparam logic [AW-1:0] LAST = AW'(NUM_BODIES - 1);
    localparam logic [AW:0] NB = (AW+1)'(NUM_BODIES);
    localparam logic signed [VEL_W+1:0] VMAX = (VEL_W+2)'(2 ** (VEL_W - 1) - 1);
    localparam logic signed [INT_W-1:0] XMAX = INT_W'(SCREEN_W - 1);
    localparam logic signed [INT_W-1:0] YMAX = INT_W'(SCREEN_H - 1);
`ifdef GRAVITY_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t state;
    logic signed [PW-1:0] px [NUM_BODIES];
    logic signed [PW-1:0] py [NUM_BODIES];
    logic signed [PW-1:0] nx [NUM_BODIES];
    logic signed [PW-1:0] ny [NUM_BODIES];
    logic signed [VEL_W-1:0] vx [NUM_BODIES];
    logic signed [VEL_W-1:0] vy [NUM_BODIES];
    logic signed [VEL_W-1:0] nvx [NUM_BODIES];
    logic signed [VEL_W-1:0] nvy [NUM_BODIES];
    logic [AW-1:0] p, q;
    logic axis, busy_r, done_r;
    logic signed [INT_W-1:0] ppx, ppy, qpx, qpy;
    logic signed [DW-1:0] dx, dy, d;
    logic [DW-1:0] m;
    logic [1:0] amag;
    logic signed [VEL_W+1:0] dv;
    logic signed [VEL_W-1:0] vc, vn;
    logic [AW:0] q1, q2;
    logic wrap, last;
    logic [NUM_BODIES*INT_W-1:0] ox, oy;

    function automatic logic signed [VEL_W-1:0] sat(input logic signed [VEL_W+1:0] s);
        return (s > VMAX) ? VMAX[VEL_W-1:0] : (s < -VMAX) ? VEL_W'(-VMAX) : s[VEL_W-1:0];
    endfunction

    function automatic logic signed [VEL_W-1:0] neg_sat(input logic signed [VEL_W-1:0] v);
        return sat(-{{2{v[VEL_W-1]}}, v});
    endfunction

    // Current micro-step: pull of body q on body p along the selected axis.
    always_comb begin
        ppx = px[p][PW-1 -: INT_W];
        ppy = py[p][PW-1 -: INT_W];
        qpx = px[q][PW-1 -: INT_W];
        qpy = py[q][PW-1 -: INT_W];
        dx = {qpx[INT_W-1], qpx} - {ppx[INT_W-1], ppx};
        dy = {qpy[INT_W-1], qpy} - {ppy[INT_W-1], ppy};
        m = (dx[DW-1] ? -dx : dx) + (dy[DW-1] ? -dy : dy);
        amag = (m >= DW'(256)) ? 2'd2 : (m >= DW'(64)) ? 2'd1 : 2'd0;
        d = axis ? dy : dx;
        vc = axis ? vy[p] : vx[p];
        dv = (d == '0) ? '0 : d[DW-1] ? -$signed({{VEL_W{1'b0}}, amag}) : $signed({{VEL_W{1'b0}}, amag});
        vn = sat({{2{vc[VEL_W-1]}}, vc} + dv);
        q1 = {1'b0, q} + (AW+1)'(1);
        q2 = (q1 == {1'b0, p}) ? q1 + (AW+1)'(1) : q1;
        wrap = q2 >= NB;
        last = axis && p == LAST && wrap;
    end

    // Frame advance: position += velocity, optionally clamped to the screen with a bounce.
    always_comb begin
        for (int i = 0; i < NUM_BODIES; i++) begin
            nx[i] = px[i] + {{(PW-VEL_W){vx[i][VEL_W-1]}}, vx[i]};
            ny[i] = py[i] + {{(PW-VEL_W){vy[i][VEL_W-1]}}, vy[i]};
            nvx[i] = vx[i];
            nvy[i] = vy[i];
            if (BOUNCE && nx[i][PW-1]) begin
                nx[i] = '0;
                nvx[i] = neg_sat(vx[i]);
            end else if (BOUNCE && $signed(nx[i][PW-1 -: INT_W]) > XMAX) begin
                nx[i] = {XMAX, {FRAC_W{1'b0}}};
                nvx[i] = neg_sat(vx[i]);
            end
            if (BOUNCE && ny[i][PW-1]) begin
                ny[i] = '0;
                nvy[i] = neg_sat(vy[i]);
            end else if (BOUNCE && $signed(ny[i][PW-1 -: INT_W]) > YMAX) begin
                ny[i] = {YMAX, {FRAC_W{1'b0}}};
                nvy[i] = neg_sat(vy[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BODIES; i++) begin
                px[i] <= {INIT_X[i*INT_W +: INT_W], {FRAC_W{1'b0}}};
                py[i] <= {INIT_Y[i*INT_W +: INT_W], {FRAC_W{1'b0}}};
                vx[i] <= '0;
                vy[i] <= '0;
            end
            p <= '0;
            q <= AW'(1);
            axis <= 1'b0;
            state <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            // A tick restarts the sweep and pre-empts any micro-step of the same cycle.
            if (bus.frame_tick) begin
                for (int i = 0; i < NUM_BODIES; i++) begin
                    px[i] <= nx[i];
                    py[i] <= ny[i];
                    vx[i] <= nvx[i];
                    vy[i] <= nvy[i];
                end
                p <= '0;
                q <= AW'(1);
                axis <= 1'b0;
                state <= SWEEP;
                busy_r <= 1'b1;
            end else if (state == SWEEP && bus.blanking) begin
                if (axis) vy[p] <= vn;
                else vx[p] <= vn;
                axis <= ~axis;
                if (last) begin
                    p <= '0;
                    q <= AW'(1);
                    state <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end else if (axis) begin
                    p <= wrap ? p + AW'(1) : p;
                    q <= wrap ? '0 : q2[AW-1:0];
                end
            end
        end
    end

    always_comb begin
        ox = '0;
        oy = '0;
        for (int i = 0; i < NUM_BODIES; i++) begin
            ox[i*INT_W +: INT_W] = px[i][PW-1 -: INT_W];
            oy[i*INT_W +: INT_W] = py[i][PW-1 -: INT_W];
        end
    end

    assign bus.pos_x = ox;
    assign bus.pos_y = oy;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_nbody_gravity.sv
// tb_nbody_gravity: randomized and directed checks of nbody_gravity against a frame/step reference model
module tb_nbody_gravity;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ft = 1'b0;
    logic bl = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    nbody_gravity_if #(.NUM_BODIES(3), .INT_W(11)) b3 ();
    nbody_gravity_if #(.NUM_BODIES(2), .INT_W(11)) b2 ();
    nbody_gravity_if #(.NUM_BODIES(2), .INT_W(11)) bb ();

    assign b3.frame_tick = ft;
    assign b3.blanking = bl;
    assign b2.frame_tick = ft;
    assign b2.blanking = bl;
    assign bb.frame_tick = ft;
    assign bb.blanking = bl;

    nbody_gravity u3 (.clk(clk), .reset(reset), .bus(b3));
    nbody_gravity #(.NUM_BODIES(2), .VEL_W(3), .INIT_X({11'sd400, 11'sd0}), .INIT_Y({11'sd0, 11'sd0}))
        u2 (.clk(clk), .reset(reset), .bus(b2));
    nbody_gravity #(.NUM_BODIES(2), .INIT_X({11'sd300, -11'sd3}), .INIT_Y({11'sd240, 11'sd240}))
        ub (.clk(clk), .reset(reset), .bus(bb));

`ifdef GRAVITY_BOUNCE_EN
    bit bounce = 1'b1;
`else
    bit bounce = 1'b0;
`endif

    int nb [3] = '{3, 2, 2};
    int vlim [3] = '{31, 3, 31};
    int ix [3][3] = '{'{270, 370, 320}, '{0, 400, 0}, '{-3, 300, 0}};
    int iy [3][3] = '{'{200, 280, 160}, '{0, 0, 0}, '{240, 240, 0}};
    int mx [3][3];
    int my [3][3];
    int mvx [3][3];
    int mvy [3][3];
    bit marm [3];
    bit mdone [3];
    int mk [3];

    function automatic int wrapw(int v, int w);
        int s;
        s = v & ((1 << w) - 1);
        return (s >= (1 << (w - 1))) ? s - (1 << w) : s;
    endfunction

    function automatic int clampv(int v, int lim);
        return (v > lim) ? lim : (v < -lim) ? -lim : v;
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                mx[k][i] = ix[k][i] * 8;
                my[k][i] = iy[k][i] * 8;
                mvx[k][i] = 0;
                mvy[k][i] = 0;
            end
            marm[k] = 1'b0;
            mdone[k] = 1'b0;
            mk[k] = 0;
        end
    endtask

    // One gravity micro-step, found by enumerating the sweep order p, q!=p, X then Y.
    task automatic m_step(input int k);
        int c, pp, qq, aa, dx, dy, m, am, d, dv, n;
        c = 0; pp = 0; qq = 0; aa = 0; n = nb[k];
        for (int p = 0; p < n; p++)
            for (int q = 0; q < n; q++)
                if (q != p)
                    for (int a = 0; a < 2; a++) begin
                        if (c == mk[k]) begin pp = p; qq = q; aa = a; end
                        c++;
                    end
        dx = wrapw((mx[k][qq] >>> 3) - (mx[k][pp] >>> 3), 12);
        dy = wrapw((my[k][qq] >>> 3) - (my[k][pp] >>> 3), 12);
        m = (iabs(dx) + iabs(dy)) & 4095;
        am = (m >= 256) ? 2 : (m >= 64) ? 1 : 0;
        d = aa ? dy : dx;
        dv = (d > 0) ? am : (d < 0) ? -am : 0;
        if (aa) mvy[k][pp] = clampv(mvy[k][pp] + dv, vlim[k]);
        else mvx[k][pp] = clampv(mvx[k][pp] + dv, vlim[k]);
        mk[k]++;
        if (mk[k] == 2 * n * (n - 1)) begin
            marm[k] = 1'b0;
            mdone[k] = 1'b1;
        end
    endtask

    task automatic m_edge(input bit f, input bit b);
        for (int k = 0; k < 3; k++) begin
            mdone[k] = 1'b0;
            if (f) begin
                for (int i = 0; i < nb[k]; i++) begin
                    mx[k][i] = wrapw(mx[k][i] + mvx[k][i], 14);
                    my[k][i] = wrapw(my[k][i] + mvy[k][i], 14);
                    if (bounce) begin
                        if ((mx[k][i] >>> 3) < 0) begin mx[k][i] = 0; mvx[k][i] = clampv(-mvx[k][i], vlim[k]); end
                        else if ((mx[k][i] >>> 3) > 639) begin mx[k][i] = 639 * 8; mvx[k][i] = clampv(-mvx[k][i], vlim[k]); end
                        if ((my[k][i] >>> 3) < 0) begin my[k][i] = 0; mvy[k][i] = clampv(-mvy[k][i], vlim[k]); end
                        else if ((my[k][i] >>> 3) > 479) begin my[k][i] = 479 * 8; mvy[k][i] = clampv(-mvy[k][i], vlim[k]); end
                    end
                end
                marm[k] = 1'b1;
                mk[k] = 0;
            end else if (marm[k] && b) begin
                m_step(k);
            end
        end
    endtask

    function automatic logic [67:0] exp3();
        logic [32:0] x, y;
        for (int i = 0; i < 3; i++) begin
            x[i*11 +: 11] = 11'(mx[0][i] >>> 3);
            y[i*11 +: 11] = 11'(my[0][i] >>> 3);
        end
        return {x, y, marm[0], mdone[0]};
    endfunction

    function automatic logic [45:0] exp2(input int k);
        logic [21:0] x, y;
        for (int i = 0; i < 2; i++) begin
            x[i*11 +: 11] = 11'(mx[k][i] >>> 3);
            y[i*11 +: 11] = 11'(my[k][i] >>> 3);
        end
        return {x, y, marm[k], mdone[k]};
    endfunction

    task automatic cyc(input bit f, input bit b);
        ft = f;
        bl = b;
        @(posedge clk);
        m_edge(f, b);
        #1;
        ft = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ft = 1'b0;
        bl = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (b3.pos_x !== {11'd320, 11'd370, 11'd270}) begin bad++; $display("FAIL reset_pos_x got %h want %h", b3.pos_x, {11'd320, 11'd370, 11'd270}); end
        total++; if (b3.pos_y !== {11'd160, 11'd280, 11'd200}) begin bad++; $display("FAIL reset_pos_y got %h want %h", b3.pos_y, {11'd160, 11'd280, 11'd200}); end
        total++; if ({b3.busy, b3.done} !== 2'b00) begin bad++; $display("FAIL reset_busy_done got %b want 00", {b3.busy, b3.done}); end
        total++; if (b2.pos_x !== {11'd400, 11'd0}) begin bad++; $display("FAIL reset_n2_pos_x got %h want %h", b2.pos_x, {11'd400, 11'd0}); end
        total++; if ({bb.pos_x, bb.busy, bb.done} !== {11'd300, 11'h7fd, 2'b00}) begin bad++; $display("FAIL reset_bounce_inst got %h want %h", {bb.pos_x, bb.busy, bb.done}, {11'd300, 11'h7fd, 2'b00}); end
        reset = 1'b0;
    endtask

    task automatic test_full_sweep();
        int pulses = 0;
        int at = -1;
        cyc(1'b1, 1'b0);
        total++; if ({b3.pos_x, b3.pos_y, b3.busy, b3.done} !== exp3()) begin bad++; $display("FAIL tick_state got %h want %h", {b3.pos_x, b3.pos_y, b3.busy, b3.done}, exp3()); end
        for (int c = 1; c <= 14; c++) begin
            cyc(1'b0, 1'b1);
            if (b3.done) begin pulses++; if (at < 0) at = c; end
            total++; if ({b3.pos_x, b3.pos_y, b3.busy, b3.done} !== exp3()) begin bad++; $display("FAIL sweep_n3 step %0d got %h want %h", c, {b3.pos_x, b3.pos_y, b3.busy, b3.done}, exp3()); end
            total++; if ({b2.pos_x, b2.pos_y, b2.busy, b2.done} !== exp2(1)) begin bad++; $display("FAIL sweep_n2 step %0d got %h want %h", c, {b2.pos_x, b2.pos_y, b2.busy, b2.done}, exp2(1)); end
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL done_pulse_count got %0d want 1", pulses); end
        total++; if (at !== 12) begin bad++; $display("FAIL done_step got %0d want 12", at); end
        cyc(1'b1, 1'b0);
        total++; if (b3.pos_x[10:0] !== 11'd270) begin bad++; $display("FAIL body0_x_after_tick got %0d want 270", b3.pos_x[10:0]); end
        total++; if ({b3.pos_x, b3.pos_y, b3.busy, b3.done} !== exp3()) begin bad++; $display("FAIL second_tick got %h want %h", {b3.pos_x, b3.pos_y, b3.busy, b3.done}, exp3()); end
    endtask

    task automatic test_stall();
        int glitches = 0;
        int n = -1;
        cyc(1'b1, 1'b0);
        repeat (5) cyc(1'b0, 1'b1);
        for (int c = 0; c < 100; c++) begin
            cyc(1'b0, 1'b0);
            if (!b3.busy || b3.done) glitches++;
        end
        total++; if (glitches !== 0) begin bad++; $display("FAIL stall_busy_held got %0d bad cycles want 0", glitches); end
        total++; if ({b3.pos_x, b3.pos_y, b3.busy, b3.done} !== exp3()) begin bad++; $display("FAIL stall_state got %h want %h", {b3.pos_x, b3.pos_y, b3.busy, b3.done}, exp3()); end
        for (int c = 1; c <= 20 && n < 0; c++) begin
            cyc(1'b0, 1'b1);
            if (b3.done) n = c;
        end
        total++; if (n !== 7) begin bad++; $display("FAIL stall_resume_steps got %0d want 7", n); end
        total++; if ({b3.pos_x, b3.pos_y, b3.busy, b3.done} !== exp3()) begin bad++; $display("FAIL stall_done_state got %h want %h", {b3.pos_x, b3.pos_y, b3.busy, b3.done}, exp3()); end
    endtask

    task automatic test_abort();
        int early = 0;
        int n = -1;
        cyc(1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            cyc(1'b0, 1'b1);
            if (b3.done) early++;
        end
        cyc(1'b1, 1'b1);
        if (b3.done) early++;
        total++; if (early !== 0) begin bad++; $display("FAIL abort_no_done got %0d pulses want 0", early); end
        for (int c = 1; c <= 20 && n < 0; c++) begin
            cyc(1'b0, 1'b1);
            if (b3.done) n = c;
        end
        total++; if (n !== 12) begin bad++; $display("FAIL abort_restart_steps got %0d want 12", n); end
        for (int f = 0; f < 4; f++) begin
            cyc(1'b1, 1'b0);
            repeat (13) cyc(1'b0, 1'b1);
            total++; if ({b3.pos_x, b3.pos_y, b3.busy, b3.done} !== exp3()) begin bad++; $display("FAIL abort_frame %0d got %h want %h", f, {b3.pos_x, b3.pos_y, b3.busy, b3.done}, exp3()); end
        end
    endtask

    task automatic test_saturation();
        pulse_reset();
        for (int f = 0; f < 20; f++) begin
            cyc(1'b1, 1'b0);
            repeat (5) cyc(1'b0, 1'b1);
            total++; if ({b2.pos_x, b2.pos_y, b2.busy, b2.done} !== exp2(1)) begin bad++; $display("FAIL sat_frame %0d got %h want %h", f, {b2.pos_x, b2.pos_y, b2.busy, b2.done}, exp2(1)); end
            total++; if (b2.pos_y !== 22'd0) begin bad++; $display("FAIL sat_y_still frame %0d got %h want 0", f, b2.pos_y); end
        end
    endtask

    task automatic test_bounce();
        logic [10:0] want;
`ifdef GRAVITY_BOUNCE_EN
        want = 11'd0;
`else
        want = 11'h7fd;
`endif
        pulse_reset();
        cyc(1'b1, 1'b0);
        total++; if (bb.pos_x[10:0] !== want) begin bad++; $display("FAIL bounce_x0 got %h want %h", bb.pos_x[10:0], want); end
        total++; if ({bb.pos_x, bb.pos_y, bb.busy, bb.done} !== exp2(2)) begin bad++; $display("FAIL bounce_state got %h want %h", {bb.pos_x, bb.pos_y, bb.busy, bb.done}, exp2(2)); end
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        total++; if ({b3.busy, b3.done} !== 2'b00) begin bad++; $display("FAIL midreset_busy got %b want 00", {b3.busy, b3.done}); end
        total++; if (b3.pos_x !== {11'd320, 11'd370, 11'd270}) begin bad++; $display("FAIL midreset_pos_x got %h want %h", b3.pos_x, {11'd320, 11'd370, 11'd270}); end
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            cyc($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)));
            total++; if ({b3.pos_x, b3.pos_y, b3.busy, b3.done} !== exp3()) begin bad++; $display("FAIL rand_n3 cycle %0d got %h want %h", c, {b3.pos_x, b3.pos_y, b3.busy, b3.done}, exp3()); end
            total++; if ({b2.pos_x, b2.pos_y, b2.busy, b2.done} !== exp2(1)) begin bad++; $display("FAIL rand_n2 cycle %0d got %h want %h", c, {b2.pos_x, b2.pos_y, b2.busy, b2.done}, exp2(1)); end
            total++; if ({bb.pos_x, bb.pos_y, bb.busy, bb.done} !== exp2(2)) begin bad++; $display("FAIL rand_nb cycle %0d got %h want %h", c, {bb.pos_x, bb.pos_y, bb.busy, bb.done}, exp2(2)); end
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_stall();
        test_abort();
        test_saturation();
        test_bounce();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
